// File: rtl/multiply_32_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds state encodings and default sizing so the multiplier and any
// future signed variant agree on them.
package multiply_32_seq_pkg;

  // FSM encodings; the unused code 2'd3 is treated as idle by the FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Default operand width (product is twice this)
  localparam int DEFAULT_WIDTH = 32;

  // Default iteration counter width; 2**CNT_W must exceed WIDTH
  localparam int DEFAULT_CNT_W = 6;

endpackage : multiply_32_seq_pkg

// File: rtl/multiply_32_seq_step.sv
// One shift-add iteration of the unsigned multiplier.
// The partial product register holds the accumulated high half in
// p[2W-1:W] and the not-yet-consumed multiplier bits in p[W-1:0].
// The current multiplier bit is p[0]. The sum is one bit wider than an
// operand, so the carry becomes the new MSB after the right shift and
// no product bit is ever dropped.
module multiply_32_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  // Add the multiplicand into the high half when the current bit is set,
  // then shift the whole register right by one
  always_comb begin
    addend = '0;
    if (p[0]) begin
      addend = {1'b0, mcand};
    end
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + addend;
    p_next = {sum, p[WIDTH-1:1]};
  end

endmodule : multiply_32_seq_step

// File: rtl/multiply_32_seq.sv
// Iterative unsigned WIDTH x WIDTH shift-add multiplier.
//
// Handshake: start is a request that is taken only in a cycle where
// ready=1; a and b are sampled on that same rising edge and ignored at all
// other times. A request while ready=0 is dropped, not queued. done pulses
// for exactly one cycle when out/out_hi/overflow carry the new product;
// those outputs then hold until the next product completes.
//
// Timing: an accept edge is followed by WIDTH iteration edges and one
// final edge that publishes the product, so done is high in the cycle after
// the (WIDTH+1)-th edge following the accept, independent of operand values.
module multiply_32_seq
  import multiply_32_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;

  // Combinational single iteration of the datapath
  multiply_32_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p),
    .mcand  (mcand),
    .p_next (p_next)
  );

  // Expose the FSM state for observation
  assign dbg_state = state;

  // FSM, iteration counter, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      out      <= '0;
      out_hi   <= '0;
      overflow <= 1'b0;
      count    <= '0;
      mcand    <= '0;
      p        <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (count == LAST_COUNT) begin
            // All WIDTH iterations are in p: publish the product
            state    <= S_DONE;
            ready    <= 1'b1;
            done     <= 1'b1;
            out      <= p[WIDTH-1:0];
            out_hi   <= p[2*WIDTH-1:WIDTH];
            overflow <= |p[2*WIDTH-1:WIDTH];
          end else begin
            p     <= p_next;
            count <= count + 1'b1;
            done  <= 1'b0;
          end
        end

        // S_IDLE, S_DONE and the unreachable code 2'd3 all accept work;
        // done drops after one cycle so it can never be high twice in a row
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            ready <= 1'b0;
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
            count <= '0;
          end else begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule : multiply_32_seq
